// File: rtl/dunit_pkg.sv
// Shared constants and state encodings for the UART debug unit.
package dunit_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_RSTPC = 8'h52;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RESET_PC,
        ST_RUN,
        ST_STEP,
        ST_DUMP_ADDR,
        ST_DUMP_LATCH,
        ST_DUMP_SEND
    } state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAIT
    } ser_state_t;

    function automatic logic [7:0] msb_byte(input logic [WORD_BITS-1:0] w);
        return w[WORD_BITS-1 -: 8];
    endfunction

endpackage

// File: rtl/dunit_word_serializer.sv
// Sends one word as BYTES_PER_WORD UART bytes, MSB first, one byte per tx_done handshake.
module dunit_word_serializer
    import dunit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] word,
    input  logic                 tx_done,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 done
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    ser_state_t           state;
    logic [WORD_BITS-1:0] shreg;
    logic [1:0]           byte_idx;

    // Completion is flagged in the same cycle as the final tx_done so the caller can move on at once.
    assign done = (state == SER_WAIT) && tx_done && (byte_idx == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SER_IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (start) begin
                        tx_data  <= msb_byte(word);
                        tx_start <= 1'b1;
                        shreg    <= word << 8;
                        byte_idx <= '0;
                        state    <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    tx_start <= 1'b0;
                    state    <= SER_WAIT;
                end
                SER_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == LAST_BYTE) begin
                            state <= SER_IDLE;
                        end else begin
                            tx_data  <= msb_byte(shreg);
                            tx_start <= 1'b1;
                            shreg    <= shreg << 8;
                            byte_idx <= byte_idx + 2'd1;
                            state    <= SER_SEND;
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART-driven pipeline debug controller: program load, run/step, PC reset and state dump.
// Define DUNIT_CYCLE_COUNT_EN to append an enabled-cycle counter word to every dump.
module debug_unit
    import dunit_pkg::*;
#(
    parameter int NB_REG    = 32,
    parameter int N_REGS    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_tx_done,
    input  logic              i_halt,
    input  logic [NB_REG-1:0] i_reg_data,
    input  logic [NB_REG-1:0] i_mem_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_clk_en,
    output logic              o_reset_pc,
    output logic              o_w_mem,
    output logic [NB_REG-1:0] o_addr,
    output logic [NB_REG-1:0] o_inst_data
);

`ifdef DUNIT_CYCLE_COUNT_EN
    localparam int DUMP_WORDS = N_REGS + MEM_WORDS + 1;
`else
    localparam int DUMP_WORDS = N_REGS + MEM_WORDS;
`endif
    localparam int         IW        = $clog2(DUMP_WORDS + 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t               state;
    logic                 halted;
    logic [7:0]           word_cnt;
    logic [7:0]           word_idx;
    logic [1:0]           byte_idx;
    logic [WORD_BITS-1:0] asm_word;
    logic [IW-1:0]        dump_idx;

    logic                 ser_start;
    logic                 ser_done;
    logic [WORD_BITS-1:0] ser_word;

    // Register words use their index as address, memory words are byte addressed.
    function automatic logic [NB_REG-1:0] dump_addr(input logic [IW-1:0] idx);
        if (int'(idx) < N_REGS)
            return NB_REG'(idx);
        else if (int'(idx) < N_REGS + MEM_WORDS)
            return NB_REG'((int'(idx) - N_REGS) * 4);
        return '0;
    endfunction

    // Pipeline enable must fall in the very cycle halt shows up, hence combinational.
    assign o_clk_en  = ((state == ST_RUN) && !i_halt) || (state == ST_STEP);
    assign ser_start = (state == ST_DUMP_LATCH);

`ifdef DUNIT_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            cyc_cnt <= '0;
        else if ((state == ST_IDLE) && i_rx_done && (i_rx_data == CMD_RSTPC))
            cyc_cnt <= '0;
        else if (o_clk_en)
            cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

    always_comb begin
        ser_word = '0;
        if (int'(dump_idx) < N_REGS)
            ser_word = WORD_BITS'(i_reg_data);
        else if (int'(dump_idx) < N_REGS + MEM_WORDS)
            ser_word = WORD_BITS'(i_mem_data);
`ifdef DUNIT_CYCLE_COUNT_EN
        else
            ser_word = cyc_cnt;
`endif
    end

    dunit_word_serializer u_ser (
        .clk      (i_clk),
        .reset    (i_reset),
        .start    (ser_start),
        .word     (ser_word),
        .tx_done  (i_tx_done),
        .tx_data  (o_tx_data),
        .tx_start (o_tx_start),
        .done     (ser_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            halted      <= 1'b0;
            word_cnt    <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            asm_word    <= '0;
            dump_idx    <= '0;
            o_reset_pc  <= 1'b0;
            o_w_mem     <= 1'b0;
            o_addr      <= '0;
            o_inst_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: state <= ST_LOAD_CNT;
                            CMD_RSTPC: begin
                                o_reset_pc <= 1'b1;
                                halted     <= 1'b0;
                                state      <= ST_RESET_PC;
                            end
                            CMD_CONT: begin
                                dump_idx <= '0;
                                o_addr   <= '0;
                                state    <= halted ? ST_DUMP_ADDR : ST_RUN;
                            end
                            CMD_STEP: begin
                                dump_idx <= '0;
                                o_addr   <= '0;
                                state    <= halted ? ST_DUMP_ADDR : ST_STEP;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD_CNT: begin
                    if (i_rx_done) begin
                        word_cnt <= i_rx_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                        state    <= (i_rx_data == 8'd0) ? ST_IDLE : ST_LOAD_BYTE;
                    end
                end
                ST_LOAD_BYTE: begin
                    if (i_rx_done) begin
                        asm_word <= {asm_word[WORD_BITS-9:0], i_rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == LAST_BYTE) begin
                            o_w_mem     <= 1'b1;
                            o_addr      <= NB_REG'({word_idx, 2'b00});
                            o_inst_data <= NB_REG'({asm_word[WORD_BITS-9:0], i_rx_data});
                            state       <= ST_LOAD_WRITE;
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    o_w_mem <= 1'b0;
                    if (word_idx == word_cnt - 8'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        word_idx <= word_idx + 8'd1;
                        state    <= ST_LOAD_BYTE;
                    end
                end
                ST_RESET_PC: begin
                    o_reset_pc <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_RUN: begin
                    if (i_halt) begin
                        halted <= 1'b1;
                        state  <= ST_DUMP_ADDR;
                    end
                end
                ST_STEP: begin
                    if (i_halt)
                        halted <= 1'b1;
                    state <= ST_DUMP_ADDR;
                end
                ST_DUMP_ADDR:  state <= ST_DUMP_LATCH;
                ST_DUMP_LATCH: state <= ST_DUMP_SEND;
                ST_DUMP_SEND: begin
                    if (ser_done) begin
                        if (dump_idx == IW'(DUMP_WORDS - 1)) begin
                            o_addr <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            dump_idx <= dump_idx + IW'(1);
                            o_addr   <= dump_addr(dump_idx + IW'(1));
                            state    <= ST_DUMP_ADDR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus queues expected writes/bytes/pulses, a monitor checks them.
module tb_debug_unit;
    import dunit_pkg::*;

    localparam int NB_REG    = 32;
    localparam int N_REGS    = 4;
    localparam int MEM_WORDS = 4;
`ifdef DUNIT_CYCLE_COUNT_EN
    localparam int DUMP_WORDS = N_REGS + MEM_WORDS + 1;
`else
    localparam int DUMP_WORDS = N_REGS + MEM_WORDS;
`endif
    localparam int DUMP_BYTES = 4 * DUMP_WORDS;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              i_tx_done;
    logic              i_halt;
    logic [NB_REG-1:0] i_reg_data;
    logic [NB_REG-1:0] i_mem_data;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              o_clk_en;
    logic              o_reset_pc;
    logic              o_w_mem;
    logic [NB_REG-1:0] o_addr;
    logic [NB_REG-1:0] o_inst_data;

    logic [7:0] stim_rx_data;
    logic       stim_rx_done;
    logic       inj_rx_done;
    logic       stall_first;
    logic       inject_last;

    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          exp_en[$];
    int          exp_rpc[$];

    int n_chk = 0;
    int n_pass = 0;
    int en_acc = 0;
    int rp_w = 0;
    int tx_idx = 0;
    int u_idx = 0;

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] reg_model(input logic [31:0] a);
        return {8'hA5, a[7:0], ~a[7:0], 8'h3C};
    endfunction

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {8'hC3, 8'h00, a[7:0] + 8'h11, a[7:0]};
    endfunction

    assign i_reg_data = reg_model(o_addr);
    assign i_mem_data = mem_model(o_addr);
    assign i_rx_done  = stim_rx_done | inj_rx_done;
    assign i_rx_data  = inj_rx_done ? CMD_RSTPC : stim_rx_data;

    debug_unit #(.NB_REG(NB_REG), .N_REGS(N_REGS), .MEM_WORDS(MEM_WORDS)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_tx_done   (i_tx_done),
        .i_halt      (i_halt),
        .i_reg_data  (i_reg_data),
        .i_mem_data  (i_mem_data),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_clk_en    (o_clk_en),
        .o_reset_pc  (o_reset_pc),
        .o_w_mem     (o_w_mem),
        .o_addr      (o_addr),
        .o_inst_data (o_inst_data)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic flag(input string name);
        n_chk++;
        $display("FAIL %s: output event seen with nothing expected", name);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_tx.push_back(w[31-8*b -: 8]);
    endtask

    task automatic push_dump(input int en, input logic [31:0] cnt);
        exp_en.push_back(en);
        for (int r = 0; r < N_REGS; r++) push_word(reg_model(32'(r)));
        for (int k = 0; k < MEM_WORDS; k++) push_word(mem_model(32'(4 * k)));
`ifdef DUNIT_CYCLE_COUNT_EN
        push_word(cnt);
`else
        if (cnt == 32'hFFFF_FFFF) exp_tx.push_back(8'h00);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk); #1;
        stim_rx_data = b;
        stim_rx_done = 1'b1;
        @(posedge i_clk); #1;
        stim_rx_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_tx.size() > 0 && t < 20000) begin
            @(negedge i_clk);
            t++;
        end
        check(name, 96'(exp_tx.size()), 96'd0);
        repeat (6) @(posedge i_clk);
    endtask

    function automatic logic [95:0] out_vec();
        return 96'({o_tx_data, o_tx_start, o_clk_en, o_reset_pc, o_w_mem, o_addr, o_inst_data});
    endfunction

    // Monitor: every visible output event is matched against the scoreboard queues.
    always @(negedge i_clk) begin
        if (o_w_mem) begin
            if (exp_wr.size() == 0) flag("unexpected_write");
            else check("write_addr_data", 96'({o_addr, o_inst_data}), 96'(exp_wr.pop_front()));
        end
        if (o_reset_pc) rp_w++;
        else if (rp_w > 0) begin
            if (exp_rpc.size() == 0) flag("unexpected_reset_pc");
            else check("reset_pc_width", 96'(rp_w), 96'(exp_rpc.pop_front()));
            rp_w = 0;
        end
        if (o_clk_en) en_acc++;
        if (o_tx_start) begin
            if (tx_idx == 0) begin
                if (exp_en.size() == 0) flag("unexpected_dump");
                else check("clk_en_cycles", 96'(en_acc), 96'(exp_en.pop_front()));
                en_acc = 0;
            end
            if (exp_tx.size() == 0) flag("unexpected_tx");
            else check("tx_byte", 96'(o_tx_data), 96'(exp_tx.pop_front()));
            tx_idx = (tx_idx == DUMP_BYTES - 1) ? 0 : tx_idx + 1;
        end
    end

    // UART model: holds each byte for a while, checks stability, then pulses tx_done.
    initial begin
        i_tx_done   = 1'b0;
        inj_rx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                logic [7:0] held;
                int d;
                int bad;
                logic inj;
                held = o_tx_data;
                bad  = 0;
                d    = (stall_first && u_idx == 0) ? 50 : 2;
                inj  = inject_last && (u_idx == DUMP_BYTES - 1);
                for (int i = 0; i < d; i++) begin
                    @(negedge i_clk);
                    if (o_tx_start || o_tx_data !== held) bad++;
                end
                check((d == 50) ? "tx_hold_stalled" : "tx_hold", 96'(bad), 96'd0);
                i_tx_done = 1'b1;
                if (inj) inj_rx_done = 1'b1;
                u_idx = (u_idx == DUMP_BYTES - 1) ? 0 : u_idx + 1;
                @(posedge i_clk); #1;
                i_tx_done   = 1'b0;
                inj_rx_done = 1'b0;
            end
        end
    end

    initial begin
        i_reset      = 1'b1;
        i_halt       = 1'b0;
        stim_rx_data = 8'h00;
        stim_rx_done = 1'b0;
        stall_first  = 1'b0;
        inject_last  = 1'b0;
        repeat (3) @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        check("reset_outputs", out_vec(), 96'd0);

        send_byte(8'h58);
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check("unknown_cmd_ignored", out_vec(), 96'd0);

        exp_wr.push_back({32'd0, 32'h12345678});
        exp_wr.push_back({32'd4, 32'hAABBCCDD});
        send_byte(CMD_LOAD);
        send_byte(8'd2);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        repeat (5) @(posedge i_clk);
        check("load_writes_done", 96'(exp_wr.size()), 96'd0);

        send_byte(CMD_LOAD);
        send_byte(8'd0);
        exp_rpc.push_back(1);
        send_byte(CMD_RSTPC);
        repeat (5) @(posedge i_clk);
        check("rpc_after_empty_load", 96'(exp_rpc.size()), 96'd0);

        // Continuous run: halt arrives after ten enabled cycles, bytes sent mid-run must be dropped.
        push_dump(10, 32'd10);
        stall_first = 1'b1;
        inject_last = 1'b1;
        send_byte(CMD_CONT);
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            stim_rx_done = (i == 2) || (i == 5);
            stim_rx_data = (i == 2) ? CMD_RSTPC : CMD_LOAD;
        end
        i_halt       = 1'b1;
        stim_rx_done = 1'b0;
        wait_drain("cont_dump_drained");
        stall_first = 1'b0;
        inject_last = 1'b0;

        push_dump(0, 32'd10);
        send_byte(CMD_STEP);
        wait_drain("halted_step_dump_drained");

        exp_rpc.push_back(1);
        send_byte(CMD_RSTPC);
        repeat (3) @(posedge i_clk); #1;
        i_halt = 1'b0;
        push_dump(1, 32'd1);
        send_byte(CMD_STEP);
        wait_drain("step1_dump_drained");
        push_dump(1, 32'd2);
        send_byte(CMD_STEP);
        wait_drain("step2_dump_drained");

        // Reset in the middle of a word; the trailing byte must not complete it.
        send_byte(CMD_LOAD);
        send_byte(8'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        check("midload_reset_outputs", out_vec(), 96'd0);
        send_byte(8'h78);
        repeat (5) @(posedge i_clk);
        exp_rpc.push_back(1);
        send_byte(CMD_RSTPC);
        repeat (5) @(posedge i_clk);

        check("final_wr_queue", 96'(exp_wr.size()), 96'd0);
        check("final_rpc_queue", 96'(exp_rpc.size()), 96'd0);
        check("final_en_queue", 96'(exp_en.size()), 96'd0);
        check("final_en_residue", 96'(en_acc), 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
